// File: rtl/mem_arb_pkg.sv
// Shared widths, requester indices and FSM state type for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 56;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;

  localparam int unsigned REQ_PTW  = 0;
  localparam int unsigned REQ_DMEM = 1;
  localparam int unsigned REQ_IMEM = 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: walker has fixed priority, data and fetch alternate when both request.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_rr,
  output logic             valid,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx
);

  always_comb begin
    valid   = |req;
    win_idx = '0;
    if (req[REQ_PTW]) begin
      win_idx = IDX_W'(REQ_PTW);
    end else if (req[REQ_DMEM] && req[REQ_IMEM]) begin
      win_idx = (last_rr == IDX_W'(REQ_DMEM)) ? IDX_W'(REQ_IMEM) : IDX_W'(REQ_DMEM);
    end else if (req[REQ_DMEM]) begin
      win_idx = IDX_W'(REQ_DMEM);
    end else if (req[REQ_IMEM]) begin
      win_idx = IDX_W'(REQ_IMEM);
    end
    win = valid ? (N'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises PTW, DMEM and IMEM onto one memory transaction at a time, with a
// watchdog that completes a never-acknowledged transaction as an error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           we,
  input  logic [N-1:0][ADDR_W-1:0] addr,
  input  logic [N-1:0][DATA_W-1:0] wdata,
  input  logic [N-1:0][STRB_W-1:0] wstrb,
  output logic [N-1:0]           gnt,
  output logic [N-1:0]           rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [STRB_W-1:0]      mem_wstrb,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_rr_q, last_rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [STRB_W-1:0] cmd_wstrb_q, cmd_wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [N-1:0]      rvalid_q, rvalid_d;

  logic              pick_valid;
  logic [N-1:0]      pick_win;
  logic [IDX_W-1:0]  pick_idx;

  mem_arb_pick #(
    .N    (N),
    .IDX_W(IDX_W)
  ) u_pick (
    .req    (req),
    .last_rr(last_rr_q),
    .valid  (pick_valid),
    .win    (pick_win),
    .win_idx(pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_rr_d   = last_rr_q;
    cnt_d       = cnt_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wstrb_d = cmd_wstrb_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    rvalid_d    = '0;
    gnt         = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Reset masks the grant so nothing is accepted during the reset cycle.
        if (pick_valid && !rst) begin
          gnt         = pick_win;
          owner_d     = pick_idx;
          cmd_we_d    = we[pick_idx];
          cmd_addr_d  = addr[pick_idx];
          cmd_wdata_d = wdata[pick_idx];
          cmd_wstrb_d = wstrb[pick_idx];
          if (pick_idx != IDX_W'(REQ_PTW)) begin
            last_rr_d = pick_idx;
          end
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Ack takes precedence over a timeout landing on the same cycle.
        if (mem_ack) begin
          rdata_d  = cmd_we_q ? '0 : mem_rdata;
          rvalid_d = N'(1) << owner_q;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d  = '0;
          err_d    = 1'b1;
          rvalid_d = N'(1) << owner_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_rr_q   <= IDX_W'(REQ_IMEM);
      cnt_q       <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wstrb_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rvalid_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_rr_q   <= last_rr_d;
      cnt_q       <= cnt_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wstrb_q <= cmd_wstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = cmd_we_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign mem_wstrb = cmd_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: grants predicted by a least-recently-granted model, responses
// predicted at grant time and checked by a monitor, memory modelled with random latency.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, we = '0;
  logic [N-1:0][ADDR_W-1:0] addr = '0;
  logic [N-1:0][DATA_W-1:0] wdata = '0;
  logic [N-1:0][STRB_W-1:0] wstrb = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DATA_W-1:0] rdata;
  logic err, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  mem_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {int owner; logic [63:0] rdata; logic err; int lat; int gcyc;} exp_t;
  typedef struct {logic we; logic [55:0] addr; logic [63:0] wdata; logic [7:0] wstrb; int delay;} mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];
  int n_checks = 0, n_err = 0, cyc = 0;
  bit model_busy = 0;
  int model_since = 0;
  int model_tg[3] = '{0, -2, -1};
  bit [2:0] gnt_seen = '0, rvalid_seen = '0, outstanding = '0, auto_mask = '0;
  int auto_rate = 0, drop_rate = 0, force_delay = 0;
  bit mem_manual = 0;
  logic manual_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req_v, cyc);
    end
  endfunction

  function automatic logic [63:0] mem_val(input logic [55:0] a);
    if (a == 56'h1000) return 64'hDEAD_BEEF;
    return {a[31:0] ^ 32'h5A5A_C3C3, a[55:24]};
  endfunction

  // Walker always first; otherwise the least recently granted of DMEM/IMEM.
  function automatic int model_pick(input logic [2:0] r);
    if (r[0]) return 0;
    if (r[1] && r[2]) return (model_tg[1] < model_tg[2]) ? 1 : 2;
    if (r[1]) return 1;
    if (r[2]) return 2;
    return -1;
  endfunction

  // Monitor: grant prediction, expectation push, response pop/compare.
  int mon_w, mon_d;
  logic [2:0] mon_eg;
  exp_t mon_e;
  mem_t mon_m;
  always @(negedge clk) begin
    if (rst) begin
      check("gnt_in_reset", 64'(gnt), 64'd0);
      exp_q.delete();
      mem_q.delete();
      model_busy = 0;
      model_tg[1] = -2;
      model_tg[2] = -1;
    end else begin
      mon_w  = model_busy ? -1 : model_pick(req);
      mon_eg = (mon_w >= 0) ? (3'b001 << mon_w) : 3'b000;
      check("gnt", 64'(gnt), 64'(mon_eg));
      if (mon_w >= 0) begin
        mon_d = (force_delay != 0) ? force_delay : int'($urandom_range(TO + 1, 1));
        mon_m.we = we[mon_w]; mon_m.addr = addr[mon_w];
        mon_m.wdata = wdata[mon_w]; mon_m.wstrb = wstrb[mon_w]; mon_m.delay = mon_d;
        mem_q.push_back(mon_m);
        mon_e.owner = mon_w;
        mon_e.err   = (mon_d > int'(TO));
        mon_e.rdata = (we[mon_w] || mon_d > int'(TO)) ? 64'd0 : mem_val(addr[mon_w]);
        mon_e.lat   = ((mon_d > int'(TO)) ? int'(TO) : mon_d) + 1;
        mon_e.gcyc  = cyc;
        exp_q.push_back(mon_e);
        model_busy = 1;
        model_since = cyc;
        if (mon_w != 0) model_tg[mon_w] = cyc;
        gnt_seen[mon_w] = 1'b1;
      end
      if (rvalid != '0) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", 64'(rvalid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rvalid_owner", 64'(rvalid), 64'(3'b001 << mon_e.owner));
          check("rdata", rdata, mon_e.rdata);
          check("err", 64'(err), 64'(mon_e.err));
          check("latency", 64'(cyc - mon_e.gcyc), 64'(mon_e.lat));
          rvalid_seen[mon_e.owner] = 1'b1;
          model_busy = 0;
        end
      end else begin
        check("err_idle", 64'(err), 64'd0);
        if (model_busy && (cyc - model_since) > int'(TO) + 3) begin
          check("rvalid_missing", 64'd0, 64'd1);
          exp_q.delete();
          mem_q.delete();
          model_busy = 0;
        end
      end
    end
  end

  // Memory model: checks the presented command and acks after the chosen latency.
  initial begin : responder
    mem_t e;
    int k, hi;
    bit active;
    logic [63:0] r;
    mem_ack = 1'b0; mem_rdata = '0; active = 0; k = 0; hi = 0;
    e = '{we: 1'b0, addr: '0, wdata: '0, wstrb: '0, delay: 0};
    forever begin
      @(posedge clk);
      #2;
      r = {$urandom, $urandom};
      mem_ack = 1'b0;
      mem_rdata = r;
      if (rst || mem_manual) begin
        active = 0;
        mem_ack = mem_manual ? manual_ack : 1'b0;
      end else begin
        if (!active && mem_req) begin
          if (mem_q.size() == 0) begin
            check("mem_req_spurious", 64'(mem_req), 64'd0);
          end else begin
            e = mem_q.pop_front();
            active = 1; k = 1; hi = 0;
          end
        end
        if (active) begin
          if (mem_req) begin
            hi++;
            check("mem_we", 64'(mem_we), 64'(e.we));
            check("mem_addr", 64'(mem_addr), 64'(e.addr));
            check("mem_wdata", mem_wdata, e.wdata);
            check("mem_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
          end
          if (k == e.delay) begin
            mem_ack = 1'b1;
            if (!e.we) mem_rdata = mem_val(e.addr);
          end
          if (!mem_req) begin
            check("mem_req_cycles", 64'(hi), 64'((e.delay > int'(TO)) ? int'(TO) : e.delay));
            active = 0;
          end
          k++;
        end
      end
    end
  end

  task automatic rand_cmd(input int w);
    logic [63:0] t;
    t = {$urandom, $urandom};
    req[w]   = 1'b1;
    we[w]    = 1'($urandom_range(1, 0));
    addr[w]  = t[55:0] & ~56'h7;
    wdata[w] = {$urandom, $urandom};
    wstrb[w] = 8'($urandom_range(255, 0));
  endtask

  task automatic issue(input int w, input logic w_we, input logic [55:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    req[w] = 1'b1; we[w] = w_we; addr[w] = a; wdata[w] = d; wstrb[w] = s;
  endtask

  // One cycle of requester behaviour: drop on grant, re-arm after own response.
  task automatic step();
    @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      if (gnt_seen[w]) begin req[w] = 1'b0; outstanding[w] = 1'b1; gnt_seen[w] = 1'b0; end
      if (rvalid_seen[w]) begin outstanding[w] = 1'b0; rvalid_seen[w] = 1'b0; end
      if (auto_mask[w] && req[w] && int'($urandom_range(99, 0)) < drop_rate) req[w] = 1'b0;
      else if (auto_mask[w] && !req[w] && !outstanding[w] &&
               int'($urandom_range(99, 0)) < auto_rate) rand_cmd(w);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 400 && !(exp_q.size() == 0 && !model_busy && req == '0 &&
                        outstanding == '0 && gnt_seen == '0)) begin
      step();
      n++;
    end
    if (n >= 400) check("drain", 64'd0, 64'd1);
  endtask

  task automatic clear_reqs();
    req = '0; outstanding = '0; gnt_seen = '0; rvalid_seen = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clear_reqs();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_reqs();
  endtask

  initial begin : driver
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single read, ack 3 cycles into the transaction.
    force_delay = 3;
    issue(1, 1'b0, 56'h1000, 64'd0, 8'hFF);
    wait_idle();
    // Write: read data must come back as zero.
    force_delay = 2;
    issue(2, 1'b1, 56'h2008, 64'h0123_4567_89AB_CDEF, 8'h0F);
    wait_idle();
    // Timeout with a late ack, then ack exactly on the timeout cycle.
    force_delay = TO + 1;
    issue(1, 1'b0, 56'h1000, 64'd0, 8'hFF);
    wait_idle();
    force_delay = TO;
    issue(0, 1'b0, 56'h1000, 64'd0, 8'hFF);
    wait_idle();

    // Reset in the middle of a DMEM read.
    mem_manual = 1;
    manual_ack = 1'b0;
    force_delay = 0;
    issue(1, 1'b0, 56'h3000, 64'd0, 8'hFF);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_reqs();
    @(negedge clk);
    check("mem_req_after_rst", 64'(mem_req), 64'd0);
    check("rvalid_after_rst", 64'(rvalid), 64'd0);
    step();
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    repeat (3) step();
    mem_manual = 0;
    force_delay = 2;
    issue(2, 1'b0, 56'h4000, 64'd0, 8'hFF);
    wait_idle();

    // Round-robin straight after reset: DMEM must go first.
    do_reset(2);
    force_delay = 0;
    drop_rate = 0;
    auto_rate = 100;
    auto_mask = 3'b110;
    repeat (40) step();
    auto_mask = '0;
    wait_idle();

    // All three at once, DMEM/IMEM keep requesting.
    issue(0, 1'b0, 56'h5000, 64'd0, 8'hFF);
    issue(1, 1'b1, 56'h5008, 64'h1111, 8'h01);
    issue(2, 1'b0, 56'h5010, 64'd0, 8'hFF);
    auto_mask = 3'b110;
    repeat (30) step();
    auto_mask = '0;
    wait_idle();

    // Random traffic with random latencies, occasional early request drops.
    auto_rate = 25;
    drop_rate = 3;
    auto_mask = 3'b111;
    repeat (3000) step();
    auto_mask = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
